// File: rtl/p2s_if.sv
// -----------------------------------------------------------------------------
// p2s_if : byte handshake between a byte producer and the p2s_ctrl serializer.
//
//   data_in     producer -> ctrl   byte to serialize
//   data_valid  producer -> ctrl   data_in is valid this cycle
//   data_ready  ctrl -> producer   ctrl accepts data_in this cycle
//
// A byte moves on a rising edge where data_valid & data_ready are both high.
// -----------------------------------------------------------------------------
interface p2s_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/p2s_ctrl.sv
// -----------------------------------------------------------------------------
// p2s_ctrl : control stage in front of an 8:1 parallel-to-serial bit mux.
//
// A byte accepted on the handshake is held in data_q while a 3-bit select
// (sel) steps through its bits, one per clock. The mux outputs data_q[sel];
// registered strobes frame each serial bit for the downstream consumer.
//
// Parameters
//   MSB_FIRST   0: sel counts 0->7, 1: sel counts 7->0
//   GAP_CYCLES  idle cycles forced between frames (0..15); 0 allows a new
//               byte to be taken on the last bit slot with no bubble
//
// Configuration macro
//   P2S_PARITY_EN  when defined, one extra slot carrying even parity of
//                  data_q follows bit 8 and ports par_bit/par_slot exist
//
// Ports
//   clk         clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   in_if       byte handshake (slave side): data_in, data_valid, data_ready
//   data_q      held byte, drives the mux data input
//   sel         bit select, drives the mux select
//   bit_valid   mux output (or parity slot) is a valid serial bit
//   first_bit   first slot of a frame
//   last_bit    final slot of a frame
//   par_bit     [P2S_PARITY_EN] even parity of data_q
//   par_slot    [P2S_PARITY_EN] current slot carries par_bit
// -----------------------------------------------------------------------------
module p2s_ctrl #(
    parameter int MSB_FIRST  = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    p2s_if.slave       in_if,
    output logic [7:0] data_q,
    output logic [2:0] sel,
    output logic       bit_valid,
    output logic       first_bit,
    output logic       last_bit
`ifdef P2S_PARITY_EN
    ,
    output logic       par_bit,
    output logic       par_slot
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_GAP    = 2'd3
    } state_e;

`ifdef P2S_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam logic [2:0] SEL_START = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
    localparam logic [2:0] SEL_END   = (MSB_FIRST != 0) ? 3'd0 : 3'd7;
    // Adding 7 modulo 8 is a decrement, so one adder serves both directions.
    localparam logic [2:0] SEL_STEP  = (MSB_FIRST != 0) ? 3'd7 : 3'd1;
    localparam bit         GAP_EN    = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LAST  = GAP_EN ? 4'(GAP_CYCLES - 1) : 4'd0;
    // A new byte may land on the bit-8 slot only when nothing follows bit 8.
    localparam bit         B2B_EN    = !GAP_EN && !PARITY_EN;

    state_e     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [2:0] sel_q, sel_d;
    logic       bit_valid_q, bit_valid_d;
    logic       first_q, first_d;
    logic       last_q, last_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
`ifdef P2S_PARITY_EN
    logic       par_slot_q, par_slot_d;
`endif

    logic [2:0] sel_inc;
    logic       at_end;
    logic       ready;
    logic       xfer;

    assign sel_inc = sel_q + SEL_STEP;
    assign at_end  = (sel_q == SEL_END);

    // Ready depends only on state, never on data_valid, so no combinational
    // path exists from valid to ready.
    assign ready = !reset &&
                   ((state_q == S_IDLE) ||
                    (B2B_EN && (state_q == S_SHIFT) && at_end));
    assign xfer  = in_if.data_valid && ready;

    assign in_if.data_ready = ready;

    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        sel_d       = sel_q;
        gap_cnt_d   = gap_cnt_q;
        bit_valid_d = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
`ifdef P2S_PARITY_EN
        par_slot_d  = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d     = S_SHIFT;
                    byte_d      = in_if.data_in;
                    sel_d       = SEL_START;
                    bit_valid_d = 1'b1;
                    first_d     = 1'b1;
                end
            end

            S_SHIFT: begin
                if (!at_end) begin
                    sel_d       = sel_inc;
                    bit_valid_d = 1'b1;
                    last_d      = !PARITY_EN && (sel_inc == SEL_END);
                end else begin
                    // Frame data done: sel reloads rather than wrapping.
                    sel_d = SEL_START;
`ifdef P2S_PARITY_EN
                    state_d     = S_PARITY;
                    bit_valid_d = 1'b1;
                    last_d      = 1'b1;
                    par_slot_d  = 1'b1;
`else
                    if (GAP_EN) begin
                        state_d   = S_GAP;
                        gap_cnt_d = 4'd0;
                    end else if (xfer) begin
                        byte_d      = in_if.data_in;
                        bit_valid_d = 1'b1;
                        first_d     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
`endif
                end
            end

            S_PARITY: begin
                if (GAP_EN) begin
                    state_d   = S_GAP;
                    gap_cnt_d = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            byte_q      <= 8'h00;
            sel_q       <= SEL_START;
            gap_cnt_q   <= 4'd0;
            bit_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
`ifdef P2S_PARITY_EN
            par_slot_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            sel_q       <= sel_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_valid_q <= bit_valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
`ifdef P2S_PARITY_EN
            par_slot_q  <= par_slot_d;
`endif
        end
    end

    assign data_q    = byte_q;
    assign sel       = sel_q;
    assign bit_valid = bit_valid_q;
    assign first_bit = first_q;
    assign last_bit  = last_q;
`ifdef P2S_PARITY_EN
    assign par_bit   = ^byte_q;
    assign par_slot  = par_slot_q;
`endif

endmodule

// File: tb/tb_p2s_ctrl.sv
// -----------------------------------------------------------------------------
// tb_p2s_ctrl : directed bench for p2s_ctrl.
//
// Three instances share clk/reset:
//   u0  MSB_FIRST=0 GAP_CYCLES=0
//   u1  MSB_FIRST=1 GAP_CYCLES=0
//   u2  MSB_FIRST=0 GAP_CYCLES=3
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_p2s_ctrl;

`ifdef P2S_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk;
    logic reset;

    logic [7:0] din  [3];
    logic       dval [3];
    wire        rdy  [3];
    wire  [7:0] dq   [3];
    wire  [2:0] sl   [3];
    wire        bv   [3];
    wire        fb   [3];
    wire        lb   [3];
`ifdef P2S_PARITY_EN
    wire        pb   [3];
    wire        ps   [3];
`endif

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MSB = (g == 1) ? 1 : 0;
        localparam int GAP = (g == 2) ? 3 : 0;

        p2s_if u_if ();

        assign u_if.data_in    = din[g];
        assign u_if.data_valid = dval[g];
        assign rdy[g]          = u_if.data_ready;

        p2s_ctrl #(
            .MSB_FIRST  (MSB),
            .GAP_CYCLES (GAP)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_if     (u_if),
            .data_q    (dq[g]),
            .sel       (sl[g]),
            .bit_valid (bv[g]),
            .first_bit (fb[g]),
            .last_bit  (lb[g])
`ifdef P2S_PARITY_EN
            ,
            .par_bit   (pb[g]),
            .par_slot  (ps[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit is_msb(input int d);
        return d == 1;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 2) ? 3 : 0;
    endfunction

    // Present a byte while the DUT is idle; returns observing slot 1.
    task automatic send(input int d, input logic [7:0] v);
        din[d]  = v;
        dval[d] = 1'b1;
        check($sformatf("u%0d send rdy", d), 32'(rdy[d]), 32'd1);
        tick();
    endtask

    task automatic check_slot(input int d, input int k, input logic [7:0] v);
        logic [2:0] es;
        string      t;
        es = is_msb(d) ? 3'(8 - k) : 3'(k - 1);
        t  = $sformatf("u%0d k%0d", d, k);
        check({t, " bit_valid"}, 32'(bv[d]), 32'd1);
        check({t, " first_bit"}, 32'(fb[d]), 32'(k == 1));
        check({t, " last_bit"},  32'(lb[d]), 32'((k == 8) && !PAR));
        check({t, " sel"},       32'(sl[d]), 32'(es));
        check({t, " data_q"},    32'(dq[d]), 32'(v));
        check({t, " mux_bit"},   32'(dq[d][sl[d]]), 32'(v[es]));
        check({t, " ready"},     32'(rdy[d]), 32'((k == 8) && (gap_of(d) == 0) && !PAR));
`ifdef P2S_PARITY_EN
        check({t, " par_slot"},  32'(ps[d]), 32'd0);
`endif
    endtask

    // Walk a whole frame starting at slot 1; from slot 1 on the handshake
    // carries nv/nval. Returns one cycle after the final slot.
    task automatic frame(input int d, input logic [7:0] v, input logic [7:0] nv, input logic nval);
        for (int k = 1; k <= 8; k++) begin
            check_slot(d, k, v);
            if (k == 1) begin
                din[d]  = nv;
                dval[d] = nval;
            end
            tick();
        end
`ifdef P2S_PARITY_EN
        check($sformatf("u%0d k9 bit_valid", d), 32'(bv[d]), 32'd1);
        check($sformatf("u%0d k9 par_slot", d),  32'(ps[d]), 32'd1);
        check($sformatf("u%0d k9 last_bit", d),  32'(lb[d]), 32'd1);
        check($sformatf("u%0d k9 first_bit", d), 32'(fb[d]), 32'd0);
        check($sformatf("u%0d k9 par_bit", d),   32'(pb[d]), 32'(^v));
        check($sformatf("u%0d k9 ready", d),     32'(rdy[d]), 32'd0);
        check($sformatf("u%0d k9 data_q", d),    32'(dq[d]), 32'(v));
        tick();
`endif
    endtask

    task automatic check_reset_vals(input string t);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s u%0d bit_valid", t, d), 32'(bv[d]), 32'd0);
            check($sformatf("%s u%0d first_bit", t, d), 32'(fb[d]), 32'd0);
            check($sformatf("%s u%0d last_bit", t, d),  32'(lb[d]), 32'd0);
            check($sformatf("%s u%0d data_q", t, d),    32'(dq[d]), 32'h00);
            check($sformatf("%s u%0d sel", t, d),       32'(sl[d]), is_msb(d) ? 32'd7 : 32'd0);
            check($sformatf("%s u%0d ready", t, d),     32'(rdy[d]), 32'd0);
`ifdef P2S_PARITY_EN
            check($sformatf("%s u%0d par_slot", t, d),  32'(ps[d]), 32'd0);
`endif
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            din[d]  = 8'h00;
            dval[d] = 1'b0;
        end

        // Reset held 3 cycles, then released.
        @(negedge clk);
        tick();
        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++)
            check($sformatf("rel u%0d ready", d), 32'(rdy[d]), 32'd1);
        @(negedge clk);

        // Single byte LSB first: bits 1,0,1,0,0,1,0,1.
        send(0, 8'hA5);
        frame(0, 8'hA5, 8'h00, 1'b0);
        check("a5 idle bit_valid", 32'(bv[0]), 32'd0);
        check("a5 idle ready", 32'(rdy[0]), 32'd1);
        check("a5 idle sel", 32'(sl[0]), 32'd0);

`ifndef P2S_PARITY_EN
        // Back-to-back with valid held: 16 contiguous bit slots.
        send(0, 8'h3C);
        frame(0, 8'h3C, 8'hC3, 1'b1);
        frame(0, 8'hC3, 8'h00, 1'b0);
        check("b2b end bit_valid", 32'(bv[0]), 32'd0);
        check("b2b end data_q", 32'(dq[0]), 32'hC3);
`endif

        // MSB first: sel 7..0.
        send(1, 8'h3C);
        frame(1, 8'h3C, 8'h00, 1'b0);
        check("msb idle bit_valid", 32'(bv[1]), 32'd0);
        check("msb idle sel", 32'(sl[1]), 32'd7);

        // Gap of 3: second byte held valid during the frame is not taken
        // until IDLE, leaving 3 gap cycles plus 1 idle cycle.
        send(2, 8'h3C);
        frame(2, 8'h3C, 8'h99, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("gap%0d bit_valid", i), 32'(bv[2]), 32'd0);
            check($sformatf("gap%0d ready", i),     32'(rdy[2]), 32'd0);
            check($sformatf("gap%0d data_q", i),    32'(dq[2]), 32'h3C);
            tick();
        end
        check("gap idle bit_valid", 32'(bv[2]), 32'd0);
        check("gap idle ready", 32'(rdy[2]), 32'd1);
        tick();
        frame(2, 8'h99, 8'h00, 1'b0);
        check("gap2 end bit_valid", 32'(bv[2]), 32'd0);

        // Reset at slot 4 of 8'hFF aborts the frame.
        send(0, 8'hFF);
        for (int k = 1; k <= 3; k++) begin
            check_slot(0, k, 8'hFF);
            if (k == 1) dval[0] = 1'b0;
            tick();
        end
        check("ff k4 sel", 32'(sl[0]), 32'd3);
        reset = 1'b1;
        tick();
        check_reset_vals("abort");
        reset = 1'b0;
        #1;
        check("abort rel ready", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        send(0, 8'h01);
        frame(0, 8'h01, 8'h00, 1'b0);
        check("01 idle bit_valid", 32'(bv[0]), 32'd0);

`ifdef P2S_PARITY_EN
        // Parity slot: ^8'h07 = 1, ^8'h03 = 0.
        send(0, 8'h07);
        frame(0, 8'h07, 8'h00, 1'b0);
        send(0, 8'h03);
        frame(0, 8'h03, 8'h00, 1'b0);
        check("par idle bit_valid", 32'(bv[0]), 32'd0);
        check("par idle par_slot", 32'(ps[0]), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
